// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the 16-bit pipelined core.
//
// Owns the PC, drives the synchronous instruction-memory address and loads
// the IF/ID pipeline register. The hazard controller's PCStall/MP outputs
// arrive here as pc_stall/mispredict.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the saturating stall_cnt
// and flush_cnt performance counters and their ports.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low
//   pc_stall       hold request (pc and IF/ID freeze)
//   mispredict     redirect request (wins over pc_stall)
//   branch_target  redirect address, used when mispredict=1
//   imem_addr      combinational next-fetch address to the ROM
//   imem_rdata     ROM data for the address presented on the previous edge
//   ifid_instr     IF/ID instruction
//   ifid_pc        IF/ID PC+1 of ifid_instr
//   ifid_valid     1 = real instruction, 0 = bubble
//   state_dbg      current FSM state, for debug/checkers
//   stall_cnt      (FETCH_PERF_CNT_EN) edges that applied a stall
//   flush_cnt      (FETCH_PERF_CNT_EN) edges that took a redirect
//
// Handshake: there is no valid/ready pair here. pc_stall and mispredict are
// sampled on every rising edge; ifid_valid qualifies ifid_instr/ifid_pc and
// a held (stalled) IF/ID keeps its valid bit unchanged.
module fetch_stage #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_stall,
  input  logic            mispredict,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic [1:0]      state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FILL     = 2'd0,
    S_RUN      = 2'd1,
    S_HOLD     = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_next_pc;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_addr;
  logic              w_load;
  logic              w_bubble;
  logic              w_take_stall;
  logic              w_take_redirect;
  logic [15:0]       r_ifid_instr;
  logic [PC_W-1:0]   r_ifid_pc;
  logic              r_ifid_valid;

  // Wraps from all-ones to zero by truncation.
  assign w_pc_inc = r_pc + PC_W'(1);

  // Next-state / address decode. REDIRECT behaves exactly like RUN; it is a
  // separate state only so the redirect cycle is observable.
  always_comb begin
    w_next_state    = r_state;
    w_next_pc       = r_pc;
    w_addr          = r_pc;
    w_load          = 1'b0;
    w_bubble        = 1'b0;
    w_take_stall    = 1'b0;
    w_take_redirect = 1'b0;
    case (r_state)
      S_FILL: begin
        // Present RESET_PC once so its data is on imem_rdata in RUN.
        // Stall and mispredict are both ignored here.
        w_next_state = S_RUN;
      end
      default: begin
        if (mispredict) begin
          w_addr          = branch_target;
          w_next_pc       = branch_target;
          w_bubble        = 1'b1;
          w_take_redirect = 1'b1;
          w_next_state    = S_REDIRECT;
        end else if (pc_stall) begin
          // Re-read the same word so imem_rdata stays valid across the hold.
          w_addr       = r_pc;
          w_take_stall = 1'b1;
          w_next_state = S_HOLD;
        end else begin
          w_addr       = w_pc_inc;
          w_next_pc    = w_pc_inc;
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FILL;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // IF/ID register. A bubble leaves ifid_pc at its previous value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_load) begin
      r_ifid_instr <= imem_rdata;
      r_ifid_pc    <= w_pc_inc;
      r_ifid_valid <= 1'b1;
    end else if (w_bubble) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_take_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_take_redirect && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  // While reset is held r_state is FILL, so this yields RESET_PC.
  assign imem_addr  = w_addr;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int          PC_W     = 8;
  localparam logic [7:0]  RST_PC   = 8'h00;
  localparam logic [15:0] NOP      = 16'h0000;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        pc_stall      = 1'b0;
  logic        mispredict    = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic [1:0]  state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  fetch_stage #(.PC_W(PC_W), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_stall      (pc_stall),
    .mispredict    (mispredict),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .state_dbg     (state_dbg)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // Synchronous ROM: one-cycle read latency.
  logic [15:0] mem [256];
  always @(posedge clock) imem_rdata <= mem[imem_addr];

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];   // {valid, pc[7:0], instr[15:0]} expected after each edge
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: f is the word address whose data the ROM is returning,
  // m_* is what IF/ID should contain.
  logic [7:0]  m_f;
  logic        m_fill;
  logic [15:0] m_instr;
  logic [7:0]  m_pc;
  logic        m_valid;
  int          m_stalls;
  int          m_flushes;

  task automatic model_reset();
    m_f = RST_PC; m_fill = 1'b1;
    m_instr = NOP; m_pc = 8'h00; m_valid = 1'b0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // Entered and left at posedge+2: drives inputs for the coming edge.
  task automatic cycle(input logic st, input logic mp, input logic [7:0] bt);
    logic [7:0] exp_addr;
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", {16'h0, stall_cnt}, m_stalls);
    check("flush_cnt", {16'h0, flush_cnt}, m_flushes);
`endif
    pc_stall = st; mispredict = mp; branch_target = bt;
    if (m_fill) begin
      exp_addr = RST_PC;
      m_fill   = 1'b0;
    end else if (mp) begin
      exp_addr = bt;
      m_f      = bt;
      m_instr  = NOP;
      m_valid  = 1'b0;
      if (m_flushes < 65535) m_flushes++;
    end else if (st) begin
      exp_addr = m_f;
      if (m_stalls < 65535) m_stalls++;
    end else begin
      m_instr  = mem[m_f];
      m_f      = m_f + 8'd1;
      m_pc     = m_f;
      m_valid  = 1'b1;
      exp_addr = m_f;
    end
    exp_q.push_back({m_valid, m_pc, m_instr});
    #1;
    check("imem_addr", {24'h0, imem_addr}, {24'h0, exp_addr});
    @(posedge clock); #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [24:0] e;
    forever begin
      @(posedge clock); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ifid_valid", {31'h0, ifid_valid}, {31'h0, e[24]});
        check("ifid_pc",    {24'h0, ifid_pc},    {24'h0, e[23:16]});
        check("ifid_instr", {16'h0, ifid_instr}, {16'h0, e[15:0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs();
    check("rst_ifid_instr", {16'h0, ifid_instr}, {16'h0, NOP});
    check("rst_ifid_pc",    {24'h0, ifid_pc},    32'h0);
    check("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_imem_addr",  {24'h0, imem_addr},  {24'h0, RST_PC});
`ifdef FETCH_PERF_CNT_EN
    check("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    check("rst_flush_cnt", {16'h0, flush_cnt}, 32'h0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[8'h20] = 16'h4ABC;

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    #1;
    reset = 1'b1;                     // released at posedge+2

    // Fill, then 1111, 2222
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    // Stall three edges with 2222 in IF/ID, then 3333
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt_3", {16'h0, stall_cnt}, 32'd3);
`endif
    cycle(1'b0, 1'b0, 8'h00);
    // Redirect to 0x20: bubble then 4ABC/pc 21
    cycle(1'b0, 1'b1, 8'h20);
    cycle(1'b0, 1'b0, 8'h00);
`ifdef FETCH_PERF_CNT_EN
    check("flush_cnt_1", {16'h0, flush_cnt}, 32'd1);
`endif
    // Mispredict and stall together: redirect wins
    cycle(1'b1, 1'b1, 8'h03);
    cycle(1'b0, 1'b0, 8'h00);
    // Wrap: redirect to FE, then FE, FF (ifid_pc wraps to 00), 00
    cycle(1'b0, 1'b1, 8'hFE);
    repeat (4) cycle(1'b0, 1'b0, 8'h00);
    // Back-to-back redirects
    cycle(1'b0, 1'b1, 8'h10);
    cycle(1'b0, 1'b1, 8'h40);
    cycle(1'b0, 1'b0, 8'h00);

    // Randomised phase
    for (int i = 0; i < 400; i++) begin
      logic st, mp;
      st = ($urandom_range(0, 3) == 0);
      mp = ($urandom_range(0, 9) == 0);
      cycle(st, mp, 8'($urandom_range(0, 255)));
    end

    // Reset asserted mid-stall
    cycle(1'b1, 1'b0, 8'h00);
    pc_stall = 1'b1;
    mispredict = 1'b1;
    branch_target = 8'h77;
    reset = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_reset_outputs();
    @(posedge clock); @(posedge clock); #2;
    check_reset_outputs();
    reset = 1'b1;
    // Mispredict/stall during FILL are ignored; then 1111, 2222, 3333
    cycle(1'b1, 1'b1, 8'h55);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    repeat (20) cycle(($urandom_range(0, 3) == 0), 1'b0, 8'h00);

    pc_stall = 1'b0; mispredict = 1'b0;
    @(posedge clock); #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC register, drives the synchronous instruction-memory address, and loads the IF/ID pipeline register. It sits directly upstream of the hazard controller: it consumes that block's `PCStall` (hold) and `MP` (mispredict/redirect) outputs and produces the IF/ID instruction that block inspects.

## Interface
- `PC_W`, default 8: PC and instruction-address width in bits; word-addressed, one 16-bit instruction per address.
- `RESET_PC`, default 0: PC value loaded on reset.
- `NOP_INSTR`, default 16'h0000: instruction word placed in IF/ID on a bubble.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = reset asserted).
- `pc_stall`  in  1  hold request from the hazard controller (its `PCStall`).
- `mispredict`  in  1  redirect request from the hazard controller (its `MP`).
- `branch_target`  in  PC_W  redirect address, sampled when `mispredict`=1.
- `imem_addr`  out  PC_W  combinational next-fetch address to the synchronous ROM/BRAM.
- `imem_rdata`  in  16  ROM data for the address presented on the previous edge.
- `ifid_instr`  out  16  IF/ID instruction register.
- `ifid_pc`  out  PC_W  IF/ID PC+1 of `ifid_instr`, modulo 2^PC_W.
- `ifid_valid`  out  1  1 = `ifid_instr` is a real instruction; 0 = bubble.
- `stall_cnt`, `flush_cnt`  out  16 each  performance counters; present only with `FETCH_PERF_CNT_EN`.

## Operation
- Registers: `pc` (address whose data is on `imem_rdata` this cycle), `state`, IF/ID (`ifid_instr`, `ifid_pc`, `ifid_valid`).
- States: FILL, RUN, HOLD, REDIRECT.
- FILL (entered on reset): `imem_addr`=`pc`=RESET_PC; IF/ID holds a bubble. Transition to RUN after one edge, irrespective of `pc_stall`. A `mispredict` in FILL is ignored.
- RUN or HOLD, per edge, with priority `mispredict` > `pc_stall` > advance:
  - `mispredict`=1: `imem_addr`=`branch_target`; `pc`<=`branch_target`; IF/ID <= bubble. Go to REDIRECT. This overrides a simultaneous `pc_stall`.
  - `pc_stall`=1: `imem_addr`=`pc`, so the ROM re-reads the same word; `pc` and IF/ID hold. Go to HOLD.
  - Otherwise: `imem_addr`=`pc`+1; `pc`<=`pc`+1; `ifid_instr`<=`imem_rdata`; `ifid_pc`<=`pc`+1; `ifid_valid`<=1. Go to RUN.
- REDIRECT: behaves exactly as RUN, so the target instruction loads on the next non-stalled edge. It exists only so counters and debug can observe the redirect cycle. A further `mispredict` is honoured.
- Bubble: `ifid_instr`=NOP_INSTR, `ifid_valid`=0. `ifid_pc` holds its previous value.
- Arithmetic: the PC increment wraps from 2^PC_W−1 to 0 with no flag.

## Timing
- Reset, asynchronous: `pc`=RESET_PC, state=FILL, `ifid_instr`=NOP_INSTR, `ifid_pc`=0, `ifid_valid`=0, counters=0. `imem_addr`=RESET_PC while reset is held.
- First valid IF/ID: on the 2nd rising edge after reset deasserts, assuming no stall. It holds mem[RESET_PC] with `ifid_pc`=RESET_PC+1.
- Fetch latency: one cycle from `imem_addr` to `imem_rdata`. Throughput is one instruction per cycle when not stalled.
- Redirect: the target instruction reaches IF/ID on the edge after the redirect edge. Exactly one bubble is inserted.
- Stall: IF/ID is stable for every stalled edge. Release resumes with no lost or duplicated instruction.
- Reset asserted mid-operation: all state clears immediately; a pending redirect or stall is discarded.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each edge that applies a stall (HOLD taken).
  - `flush_cnt` increments on each edge that takes a redirect.
  - Both saturate at 16'hFFFF and are cleared by reset.
- `FETCH_PERF_CNT_EN` undefined: both counters and ports are absent; behaviour is otherwise identical.

## Test plan
- Reset release, ROM[0..3]=16'h1111,2222,3333,4444 -> IF/ID 16'h1111/pc 1/valid 1 on 2nd edge, then 2222, 3333 on consecutive edges.
- `pc_stall` high for 3 cycles while IF/ID=16'h2222 -> IF/ID and `pc` frozen for 3 edges; 16'h3333 loads on the first edge after release; `stall_cnt`=3.
- `mispredict`=1 with `branch_target`=8'h20, ROM[0x20]=16'h4ABC -> bubble (NOP, valid 0) on that edge, then 16'h4ABC/pc 8'h21 on the next; `flush_cnt`=1.
- `mispredict` and `pc_stall` both 1 -> redirect taken, `stall_cnt` unchanged.
- `pc` at 8'hFF, no stall -> next `imem_addr`=8'h00; IF/ID holds mem[0xFF] with `ifid_pc`=8'h00.
- `reset` low mid-stall -> all outputs take reset values immediately; fetch restarts at RESET_PC with a FILL bubble.
